fsm_response_return_unit: RTL and testbench
===========================================

# fsm_response_return_unit

Collects read-response beats from the per-(channel, rank) memory FSMs and returns them on a single AXI-style read-response channel. Each FSM's local address is translated back into the AXI physical address by prepending the FSM index as the top address bits, so FSM index = {channel, rank}. The block sits on the return path between the FSM array and the AXI frontend. It does round-robin arbitration with burst locking and has a small output FIFO for decoupling.

## Interface
Parameters:
- NUM_FSM, 8: number of FSMs; one per (channel, rank).
- NUM_FSM_BIT, $clog2(NUM_FSM): FSM index width, equal to CHWIDTH + RKWIDTH.
- AXI_ADDRWIDTH, 32: width of the AXI address.
- DATAWIDTH, 64: width of a response beat.
- IDWIDTH, 4: width of the AXI transaction ID.
- FIFO_DEPTH, 4: number of output FIFO entries; must be a power of two and ≥ 2.

Ports (`LOWW = AXI_ADDRWIDTH - NUM_FSM_BIT`; per-FSM buses are flattened, with FSM i in slice i):
- clk, input, 1: the single clock.
- rst, input, 1: synchronous, active-high reset.
- fsmRspValid, input, NUM_FSM: per-FSM beat valid.
- fsmRspReady, output, NUM_FSM: per-FSM beat accept.
- fsmRspData, input, NUM_FSM*DATAWIDTH: per-FSM beat data.
- fsmRspId, input, NUM_FSM*IDWIDTH: per-FSM transaction ID.
- fsmRspLast, input, NUM_FSM: last beat of the burst.
- fsmRspLowAddr, input, NUM_FSM*LOWW: address bits below the FSM field ({bg, bk, row, col}).
- rspValid, output, 1: AXI-side beat valid.
- rspReady, input, 1: AXI-side accept.
- rspData, output, DATAWIDTH: returned data.
- rspId, output, IDWIDTH: returned ID.
- rspLast, output, 1: last beat of the burst.
- rspAddr, output, AXI_ADDRWIDTH: reconstructed address, {fsmIndex, lowAddr}.
- rspFsmIndex, output, NUM_FSM_BIT: source FSM of the beat.

## Operation
- **State:** rrPtr (NUM_FSM_BIT), locked (1), lockIdx (NUM_FSM_BIT), FIFO storage, wrPtr, rdPtr, count (0..FIFO_DEPTH).
- **Arbitration (combinational):**
  - If locked, grant = lockIdx.
  - Otherwise, grant = the first i with fsmRspValid[i], scanning rrPtr, rrPtr+1, … modulo NUM_FSM.
  - If there is no valid request, there is no grant.
- **Ready:** fsmRspReady[grant] = (count < FIFO_DEPTH). All other ready bits are 0. Ready never depends on rspReady, so there is no full-FIFO pass-through.
- **Accept:** a beat is accepted when fsmRspValid[g] && fsmRspReady[g]. On accept, push {data, id, last, g, lowAddr}.
  - Accepted with last=0: set locked=1 and lockIdx=g.
  - Accepted with last=1: set locked=0 and rrPtr=(g+1) mod NUM_FSM.
  - rrPtr does not move on non-last beats or idle cycles.
- **Burst lock:** while locked, no other FSM receives ready, even if lockIdx drops valid.
- **Output:** rsp* shows the FIFO head; rspValid = (count != 0). Pop when rspValid && rspReady. rspAddr = {head.fsmIndex, head.lowAddr}.
- **FIFO arithmetic:**
  - Pointers wrap modulo FIFO_DEPTH.
  - Push only: count+1. Pop only: count-1. Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop is legal with count = FIFO_DEPTH; the freed slot is seen by ready the next cycle.
- **AXI ordering rule:** rspValid must stay asserted, and the head must not change, until it is popped.

## Timing
- Reset values:
  - fsmRspReady: 0.
  - rspValid, rspLast: 0.
  - rspData, rspId, rspAddr, rspFsmIndex: 0 (head of a cleared FIFO).
  - rrPtr, locked, lockIdx, count, wrPtr, rdPtr: 0.
- During reset, fsmRspReady is held at 0 regardless of count.
- Reset mid-burst drops the lock and all FIFO contents. No partial beat survives.
- Latency: a beat accepted at edge N appears with rspValid=1 after edge N, i.e. in cycle N+1. Minimum latency is 1 cycle.
- Throughput: 1 beat/cycle when rspReady is held high.
- Full: with count=FIFO_DEPTH and no pop, all ready bits are 0. After a pop at edge N, ready is reasserted in cycle N+1.
- Wrap-around: correct data order across pointer wrap for more than FIFO_DEPTH consecutive beats.

## Test plan
- **Single beat:** FSM 5 sends last=1, id=3, lowAddr=0x0ABCDE0, with rspReady=1.
  - Expect rspValid 1 cycle later, rspAddr={3'd5, lowAddr}, rspFsmIndex=5, rspId=3.
  - Expect rrPtr=6 after the accept.
- **Round-robin fairness:** FSMs 0, 2, 7 hold valid with last=1 every beat, rrPtr=0.
  - Expect accept order 0, 2, 7, 0, 2, 7.
- **Burst lock:** FSM 1 sends a 4-beat burst (last on beat 4) while FSM 2 is valid throughout.
  - Expect fsmRspReady[2]=0 until FSM 1's last beat is accepted, then FSM 2 is granted next.
  - Inject a 2-cycle valid gap inside FSM 1's burst; the lock must hold across it.
- **Full/backpressure:** rspReady=0 while FSM 4 streams 6 beats.
  - Expect exactly 4 accepted, then ready=0.
  - Raise rspReady: expect ready back one cycle after the first pop, and all 6 beats delivered in order across pointer wrap.
- **Simultaneous push/pop at full:** count=4, rspReady=1, valid pending.
  - Pop in cycle N: count goes to 3, then push+pop keeps count at 3 steady, 1 beat/cycle, no loss or duplication.
- **Reset mid-burst:** assert rst after beat 2 of a 4-beat burst with 2 entries in the FIFO.
  - Next cycle: rspValid=0, count=0, locked=0, rrPtr=0, all ready bits 0 while rst=1.

Source files
------------

// File: rtl/fsm_response_return_unit.sv
// ---------------------------------------------------------------------------
// fsm_response_return_unit
//
// Gathers read-response beats from the per-(channel, rank) memory FSMs and
// returns them on one AXI-style read-response channel. A round-robin arbiter
// picks the next FSM. Once a burst has started, the arbiter stays locked on
// that FSM until its last beat. Accepted beats go through a small FIFO. The
// AXI physical address is rebuilt by prepending the FSM index ({channel, rank})
// to the FSM-local address.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   fsmRspValid      - per-FSM beat valid            [NUM_FSM]
//   fsmRspReady      - per-FSM beat accept           [NUM_FSM]
//   fsmRspData       - per-FSM beat data             [NUM_FSM*DATAWIDTH]
//   fsmRspId         - per-FSM transaction ID        [NUM_FSM*IDWIDTH]
//   fsmRspLast       - per-FSM last-beat flag        [NUM_FSM]
//   fsmRspLowAddr    - per-FSM address below index   [NUM_FSM*LOWW]
//   rspValid/Ready   - AXI-side handshake
//   rspData, rspId, rspLast, rspAddr, rspFsmIndex - FIFO head contents
// ---------------------------------------------------------------------------
module fsm_response_return_unit #(
    parameter int NUM_FSM       = 8,
    parameter int NUM_FSM_BIT   = $clog2(NUM_FSM),
    parameter int AXI_ADDRWIDTH = 32,
    parameter int DATAWIDTH     = 64,
    parameter int IDWIDTH       = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_FSM-1:0]                             fsmRspValid,
    output logic [NUM_FSM-1:0]                             fsmRspReady,
    input  logic [NUM_FSM*DATAWIDTH-1:0]                   fsmRspData,
    input  logic [NUM_FSM*IDWIDTH-1:0]                     fsmRspId,
    input  logic [NUM_FSM-1:0]                             fsmRspLast,
    input  logic [NUM_FSM*(AXI_ADDRWIDTH-NUM_FSM_BIT)-1:0] fsmRspLowAddr,
    output logic                                           rspValid,
    input  logic                                           rspReady,
    output logic [DATAWIDTH-1:0]                           rspData,
    output logic [IDWIDTH-1:0]                             rspId,
    output logic                                           rspLast,
    output logic [AXI_ADDRWIDTH-1:0]                       rspAddr,
    output logic [NUM_FSM_BIT-1:0]                         rspFsmIndex
);

    localparam int LOWW  = AXI_ADDRWIDTH - NUM_FSM_BIT;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]       DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [NUM_FSM_BIT-1:0] LAST_IDX = NUM_FSM_BIT'(NUM_FSM - 1);
    localparam logic [NUM_FSM_BIT:0]   NUM_C    = (NUM_FSM_BIT + 1)'(NUM_FSM);

    typedef struct packed {
        logic [DATAWIDTH-1:0]   data;
        logic [IDWIDTH-1:0]     id;
        logic                   last;
        logic [NUM_FSM_BIT-1:0] idx;
        logic [LOWW-1:0]        low;
    } entry_t;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    state_e                 state_q, state_d;
    logic [NUM_FSM_BIT-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_FSM_BIT-1:0] lock_idx_q, lock_idx_d;

    entry_t                 mem_q [FIFO_DEPTH];
    entry_t                 mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   grant_valid;
    logic [NUM_FSM_BIT-1:0] grant_idx;
    logic [NUM_FSM_BIT:0]   scan_sum;
    logic [NUM_FSM_BIT-1:0] scan_idx;
    logic                   accept;
    logic                   pop;
    entry_t                 push_entry;
    entry_t                 head;

    // Arbiter state register: lock state, locked FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Next-state logic. A non-last beat locks the arbiter onto its source.
    // A last beat releases the lock and moves priority past the source.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            if (push_entry.last) begin
                state_d  = ST_IDLE;
                rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + NUM_FSM_BIT'(1);
            end else begin
                state_d    = ST_LOCKED;
                lock_idx_d = grant_idx;
            end
        end
    end

    // Output logic: the grant and the per-FSM ready bits.
    // When locked, the locked FSM keeps the grant even if it drops valid
    // mid-burst, so no other FSM can interleave into the burst.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        if (state_q == ST_LOCKED) begin
            grant_valid = 1'b1;
            grant_idx   = lock_idx_q;
        end else begin
            for (int k = 0; k < NUM_FSM; k++) begin
                scan_sum = {1'b0, rr_ptr_q} + (NUM_FSM_BIT + 1)'(k);
                if (scan_sum >= NUM_C) begin
                    scan_sum = scan_sum - NUM_C;
                end
                scan_idx = scan_sum[NUM_FSM_BIT-1:0];
                if (!grant_valid && fsmRspValid[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
        fsmRspReady = '0;
        if (!rst && grant_valid && (count_q != DEPTH_C)) begin
            fsmRspReady[grant_idx] = 1'b1;
        end
    end

    // Steer the granted FSM's beat into a FIFO entry. The address field is
    // stored as the FSM index plus the local address.
    always_comb begin
        push_entry = '0;
        for (int i = 0; i < NUM_FSM; i++) begin
            if (grant_idx == NUM_FSM_BIT'(i)) begin
                push_entry.data = fsmRspData[i*DATAWIDTH +: DATAWIDTH];
                push_entry.id   = fsmRspId[i*IDWIDTH +: IDWIDTH];
                push_entry.last = fsmRspLast[i];
                push_entry.low  = fsmRspLowAddr[i*LOWW +: LOWW];
            end
        end
        push_entry.idx = grant_idx;
    end

    assign accept = |(fsmRspValid & fsmRspReady);
    assign pop    = (count_q != '0) && rspReady;

    // FIFO bookkeeping. Pointers wrap naturally because the depth is a power
    // of two. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage is cleared on reset so the visible head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign rspValid    = (count_q != '0);
    assign rspData     = head.data;
    assign rspId       = head.id;
    assign rspLast     = head.last;
    assign rspFsmIndex = head.idx;
    assign rspAddr     = {head.idx, head.low};

endmodule

// File: tb/tb_fsm_response_return_unit.sv
// ---------------------------------------------------------------------------
// tb_fsm_response_return_unit
//
// Self-checking bench for fsm_response_return_unit. It has three parts:
//   - A table of per-cycle vectors that covers round-robin order, burst
//     locking across a valid gap, and pointer movement after a single beat.
//   - Hand-written sequences for the single beat, full FIFO/backpressure,
//     push+pop at full, and reset in the middle of a burst.
//   - A scoreboard queue. Each accepted beat is pushed as {data, id, last,
//     index, address}. The queue is popped and compared on every AXI pop.
// ---------------------------------------------------------------------------
module tb_fsm_response_return_unit;

    localparam int NUM_FSM = 8;
    localparam int NB      = 3;
    localparam int AW      = 32;
    localparam int DW      = 64;
    localparam int IW      = 4;
    localparam int FD      = 4;
    localparam int LOWW    = AW - NB;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_FSM-1:0]      fsmRspValid;
    logic [NUM_FSM-1:0]      fsmRspReady;
    logic [NUM_FSM*DW-1:0]   fsmRspData;
    logic [NUM_FSM*IW-1:0]   fsmRspId;
    logic [NUM_FSM-1:0]      fsmRspLast;
    logic [NUM_FSM*LOWW-1:0] fsmRspLowAddr;
    logic                    rspValid;
    logic                    rspReady;
    logic [DW-1:0]           rspData;
    logic [IW-1:0]           rspId;
    logic                    rspLast;
    logic [AW-1:0]           rspAddr;
    logic [NB-1:0]           rspFsmIndex;

    logic [DW-1:0]   dat [NUM_FSM];
    logic [IW-1:0]   idv [NUM_FSM];
    logic [LOWW-1:0] low [NUM_FSM];

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          last;
        logic [NB-1:0] idx;
        logic [AW-1:0] addr;
    } beat_t;

    typedef struct {
        logic [7:0] valid;
        logic [7:0] last;
        logic       rdy;
        logic [7:0] exp_ready;
        logic       exp_rsp_valid;
    } vec_t;

    beat_t sb_q[$];
    vec_t  vecs[22];
    int    vec_count  = 0;
    int    miss_count = 0;
    int    seq        = 0;
    int    sent;

    fsm_response_return_unit #(
        .NUM_FSM(NUM_FSM), .NUM_FSM_BIT(NB), .AXI_ADDRWIDTH(AW),
        .DATAWIDTH(DW), .IDWIDTH(IW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .fsmRspValid(fsmRspValid), .fsmRspReady(fsmRspReady),
        .fsmRspData(fsmRspData), .fsmRspId(fsmRspId),
        .fsmRspLast(fsmRspLast), .fsmRspLowAddr(fsmRspLowAddr),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
        .rspId(rspId), .rspLast(rspLast), .rspAddr(rspAddr),
        .rspFsmIndex(rspFsmIndex)
    );

    always #5 clk = ~clk;

    // Flatten the per-FSM stimulus arrays onto the DUT buses.
    always_comb begin
        for (int i = 0; i < NUM_FSM; i++) begin
            fsmRspData[i*DW +: DW]       = dat[i];
            fsmRspId[i*IW +: IW]         = idv[i];
            fsmRspLowAddr[i*LOWW +: LOWW] = low[i];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] valid, input logic [7:0] last,
                                 input logic rdy);
        fsmRspValid = valid;
        fsmRspLast  = last;
        rspReady    = rdy;
        for (int i = 0; i < NUM_FSM; i++) begin
            dat[i] = {8'(i), 24'(seq), 32'hCAFE_0000};
            idv[i] = IW'(i + seq);
            low[i] = LOWW'(seq * 16 + i);
        end
        seq++;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst         = 1'b1;
        fsmRspValid = '0;
        rspReady    = 1'b0;
        nextCycle();
        nextCycle();
        sb_q.delete();
        rst = 1'b0;
    endtask

    // Scoreboard. On each falling edge, a pending AXI pop is checked against
    // the oldest expected beat. A pending FSM accept is recorded as a new
    // expected beat. Both take effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rspValid && rspReady) begin
                if (sb_q.size() == 0) begin
                    vec_count++;
                    miss_count++;
                    $display("[TB] FAIL sb_pop: got beat from fsm %0d, expected none", rspFsmIndex);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    checkOutput("sb_data", 64'(rspData), 64'(e.data));
                    checkOutput("sb_meta", 64'({rspId, rspLast, rspFsmIndex, rspAddr}),
                                64'({e.id, e.last, e.idx, e.addr}));
                end
            end
            if ($countones(fsmRspReady) > 1) begin
                vec_count++;
                miss_count++;
                $display("[TB] FAIL ready_onehot: got 0x%0h, expected at most one bit", fsmRspReady);
            end
            for (int i = 0; i < NUM_FSM; i++) begin
                if (fsmRspValid[i] && fsmRspReady[i]) begin
                    beat_t b;
                    b.data = dat[i];
                    b.id   = idv[i];
                    b.last = fsmRspLast[i];
                    b.idx  = NB'(i);
                    b.addr = {NB'(i), low[i]};
                    sb_q.push_back(b);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        miss_count++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Per-cycle vectors: {valid, last, rspReady, expected ready, expected rspValid}.
        vecs[0]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[1]  = '{8'h85, 8'hFF, 1'b1, 8'h01, 1'b0};
        vecs[2]  = '{8'h85, 8'hFF, 1'b1, 8'h04, 1'b1};
        vecs[3]  = '{8'h85, 8'hFF, 1'b1, 8'h80, 1'b1};
        vecs[4]  = '{8'h85, 8'hFF, 1'b1, 8'h01, 1'b1};
        vecs[5]  = '{8'h85, 8'hFF, 1'b1, 8'h04, 1'b1};
        vecs[6]  = '{8'h85, 8'hFF, 1'b1, 8'h80, 1'b1};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[8]  = '{8'h06, 8'h04, 1'b1, 8'h02, 1'b0};
        vecs[9]  = '{8'h06, 8'h04, 1'b1, 8'h02, 1'b1};
        vecs[10] = '{8'h04, 8'h04, 1'b1, 8'h02, 1'b1};
        vecs[11] = '{8'h04, 8'h04, 1'b1, 8'h02, 1'b0};
        vecs[12] = '{8'h06, 8'h04, 1'b1, 8'h02, 1'b0};
        vecs[13] = '{8'h06, 8'h06, 1'b1, 8'h02, 1'b1};
        vecs[14] = '{8'h04, 8'h04, 1'b1, 8'h04, 1'b1};
        vecs[15] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[16] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[17] = '{8'h20, 8'hFF, 1'b1, 8'h20, 1'b0};
        vecs[18] = '{8'h61, 8'hFF, 1'b1, 8'h40, 1'b1};
        vecs[19] = '{8'h21, 8'hFF, 1'b1, 8'h01, 1'b1};
        vecs[20] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[21] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0};

        // Reset: ready stays low even with every FSM requesting.
        rst = 1'b1;
        applyStimulus(8'hFF, 8'hFF, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("ready_in_reset", 64'(fsmRspReady), 64'h0);
        nextCycle();
        rst         = 1'b0;
        fsmRspValid = '0;
        @(negedge clk);
        checkOutput("reset_rsp_valid", 64'(rspValid), 64'h0);
        checkOutput("reset_rsp_last", 64'(rspLast), 64'h0);
        checkOutput("reset_rsp_data", 64'(rspData), 64'h0);
        checkOutput("reset_rsp_id", 64'(rspId), 64'h0);
        checkOutput("reset_rsp_addr", 64'(rspAddr), 64'h0);
        checkOutput("reset_rsp_index", 64'(rspFsmIndex), 64'h0);
        checkOutput("reset_ready", 64'(fsmRspReady), 64'h0);
        nextCycle();

        // Table-driven arbitration / lock vectors.
        for (int v = 0; v < 22; v++) begin
            applyStimulus(vecs[v].valid, vecs[v].last, vecs[v].rdy);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ready", v), 64'(fsmRspReady), 64'(vecs[v].exp_ready));
            checkOutput($sformatf("vec%0d_rsp_valid", v), 64'(rspValid), 64'(vecs[v].exp_rsp_valid));
            nextCycle();
        end
        checkOutput("table_drained", 64'(sb_q.size()), 64'h0);

        // Single beat from FSM 5, then check that the pointer moved to 6.
        doReset();
        dat[5] = 64'h1122_3344_5566_7788;
        idv[5] = 4'd3;
        low[5] = 29'h0ABCDE0;
        fsmRspValid = 8'h20;
        fsmRspLast  = 8'h20;
        rspReady    = 1'b1;
        @(negedge clk);
        checkOutput("single_ready", 64'(fsmRspReady), 64'h20);
        checkOutput("single_latency0", 64'(rspValid), 64'h0);
        nextCycle();
        fsmRspValid = '0;
        @(negedge clk);
        checkOutput("single_valid", 64'(rspValid), 64'h1);
        checkOutput("single_addr", 64'(rspAddr), 64'hA0AB_CDE0);
        checkOutput("single_index", 64'(rspFsmIndex), 64'h5);
        checkOutput("single_id", 64'(rspId), 64'h3);
        checkOutput("single_last", 64'(rspLast), 64'h1);
        nextCycle();
        fsmRspValid = 8'h41;
        fsmRspLast  = 8'h41;
        @(negedge clk);
        checkOutput("single_rr_next", 64'(fsmRspReady), 64'h40);
        nextCycle();
        fsmRspValid = '0;
        nextCycle();
        nextCycle();
        checkOutput("single_drained", 64'(sb_q.size()), 64'h0);

        // Full FIFO / backpressure: FSM 4 streams 6 beats into a blocked output.
        doReset();
        sent        = 0;
        fsmRspLast  = 8'h10;
        for (int c = 0; c < 8; c++) begin
            dat[4] = {32'hB0B0_0000, 32'(sent)};
            idv[4] = IW'(sent);
            low[4] = LOWW'(sent + 100);
            fsmRspValid = 8'h10;
            @(negedge clk);
            checkOutput($sformatf("full_ready_c%0d", c), 64'(fsmRspReady),
                        (c < 4) ? 64'h10 : 64'h0);
            if (fsmRspReady[4]) sent++;
            nextCycle();
        end
        checkOutput("full_accepted", 64'(sent), 64'd4);
        rspReady = 1'b1;
        @(negedge clk);
        checkOutput("full_pop_cycle_ready", 64'(fsmRspReady), 64'h0);
        checkOutput("full_pop_cycle_valid", 64'(rspValid), 64'h1);
        nextCycle();
        for (int c = 0; c < 20 && !(sent == 6 && sb_q.size() == 0); c++) begin
            if (sent < 6) begin
                dat[4] = {32'hB0B0_0000, 32'(sent)};
                idv[4] = IW'(sent);
                low[4] = LOWW'(sent + 100);
                fsmRspValid = 8'h10;
            end else begin
                fsmRspValid = '0;
            end
            @(negedge clk);
            if (c == 0) checkOutput("ready_after_pop", 64'(fsmRspReady), 64'h10);
            if (fsmRspValid[4] && fsmRspReady[4]) sent++;
            nextCycle();
        end
        fsmRspValid = '0;
        checkOutput("stream_sent", 64'(sent), 64'd6);
        checkOutput("stream_drained", 64'(sb_q.size()), 64'h0);

        // Push and pop at full: the count settles at 3 and one beat moves per cycle.
        doReset();
        sent       = 0;
        fsmRspLast = 8'h08;
        for (int c = 0; c < 5; c++) begin
            dat[3] = {32'hF00D_0000, 32'(sent)};
            idv[3] = IW'(sent + 7);
            low[3] = LOWW'(sent * 3);
            fsmRspValid = 8'h08;
            @(negedge clk);
            if (fsmRspReady[3]) sent++;
            nextCycle();
        end
        checkOutput("pp_filled", 64'(sent), 64'd4);
        rspReady = 1'b1;
        @(negedge clk);
        checkOutput("pp_first_pop_ready", 64'(fsmRspReady), 64'h0);
        nextCycle();
        for (int c = 0; c < 6; c++) begin
            dat[3] = {32'hF00D_0000, 32'(sent)};
            idv[3] = IW'(sent + 7);
            low[3] = LOWW'(sent * 3);
            @(negedge clk);
            checkOutput($sformatf("pp_ready_c%0d", c), 64'(fsmRspReady), 64'h08);
            checkOutput($sformatf("pp_valid_c%0d", c), 64'(rspValid), 64'h1);
            if (fsmRspReady[3]) sent++;
            nextCycle();
        end
        fsmRspValid = '0;
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) nextCycle();
        checkOutput("pp_drained", 64'(sb_q.size()), 64'h0);

        // Reset in the middle of a burst: two beats from FSM 6 are buffered
        // and the arbiter is locked when reset arrives.
        doReset();
        fsmRspValid = 8'h40;
        fsmRspLast  = 8'h00;
        dat[6] = 64'hDEAD_0000_0000_0001;
        @(negedge clk);
        checkOutput("rst_burst_b0", 64'(fsmRspReady), 64'h40);
        nextCycle();
        dat[6] = 64'hDEAD_0000_0000_0002;
        @(negedge clk);
        checkOutput("rst_burst_b1", 64'(fsmRspReady), 64'h40);
        nextCycle();
        rst         = 1'b1;
        fsmRspValid = 8'h46;
        fsmRspLast  = 8'h06;
        @(negedge clk);
        checkOutput("rst_ready_gated", 64'(fsmRspReady), 64'h0);
        checkOutput("rst_pre_valid", 64'(rspValid), 64'h1);
        sb_q.delete();
        nextCycle();
        @(negedge clk);
        checkOutput("rst_rsp_valid", 64'(rspValid), 64'h0);
        checkOutput("rst_rsp_data", 64'(rspData), 64'h0);
        checkOutput("rst_rsp_addr", 64'(rspAddr), 64'h0);
        checkOutput("rst_ready_held", 64'(fsmRspReady), 64'h0);
        nextCycle();
        rst         = 1'b0;
        fsmRspValid = 8'h06;
        @(negedge clk);
        checkOutput("post_rst_grant", 64'(fsmRspReady), 64'h02);
        nextCycle();
        fsmRspValid = '0;
        rspReady    = 1'b1;
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) nextCycle();
        @(negedge clk);
        checkOutput("post_rst_drained", 64'(sb_q.size()), 64'h0);
        checkOutput("post_rst_idle", 64'(rspValid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
